// File: rtl/audio_interp_fifo_if.sv
// Sample-stream and DAC-side signals of the interpolating audio FIFO.
// The bench drives through master; the interpolator sits behind slave.
interface audio_interp_fifo_if #(
  parameter int signalwidth = 16
);
  logic [signalwidth-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [signalwidth-1:0] d;
  logic                   underrun;
  logic [2:0]             fifo_level;

  modport master (
    output in_data, in_valid,
    input  in_ready, d, underrun, fifo_level
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, d, underrun, fifo_level
  );
endinterface

// File: rtl/audio_interp_fifo.sv
// Four-entry sample FIFO feeding a linear interpolator.
// Each segment ramps the DAC code from the previous sample to the current one in 2^steplog2 equal steps.
module audio_interp_fifo #(
  parameter int signalwidth = 16,
  parameter int steplog2    = 5,
  parameter int stepdiv     = 32
) (
  input logic                clk,
  input logic                reset,
  audio_interp_fifo_if.slave bus
);

  localparam int accwidth = signalwidth + steplog2;
  localparam int divwidth = $clog2(stepdiv);
  localparam logic [divwidth-1:0] div_last = divwidth'(stepdiv - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t                        state, state_next;
  logic [signalwidth-1:0]        mem [4];
  logic [1:0]                    wr_ptr, rd_ptr;
  logic [2:0]                    level;
  logic [divwidth-1:0]           div;
  logic [steplog2-1:0]           step;
  logic signed [signalwidth-1:0] cur, prev;
  logic signed [signalwidth:0]   delta;
  logic signed [accwidth-1:0]    acc;
  logic                          push, pop, hold, tick, wrap, empty;

  assign empty = (level == 3'd0);
  assign tick  = (div == div_last);
  assign wrap  = (step == '1);
  assign push  = bus.in_valid && bus.in_ready;
  // One extra bit so the slope between any two samples is representable.
  assign delta = (signalwidth + 1)'(cur) - (signalwidth + 1)'(prev);

  assign bus.in_ready   = (level < 3'd4);
  assign bus.fifo_level = level;
  assign bus.underrun   = hold;
  assign bus.d          = {~acc[accwidth-1], acc[accwidth-2:steplog2]};

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves an output unassigned and infers a latch.
    state_next = state;
    pop        = 1'b0;
    hold       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = RAMP;
        end
      end
      RAMP: begin
        if (tick && wrap) begin
          if (empty) hold = 1'b1;
          else       pop  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the sample storage has no reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      level <= level + {2'b00, push} - {2'b00, pop};
    end
  end

  // acc holds the output value scaled by 2^steplog2; N slope additions land exactly on cur.
  always_ff @(posedge clk) begin
    if (reset) begin
      div  <= '0;
      step <= '0;
      cur  <= '0;
      prev <= '0;
      acc  <= '0;
    end else if (state == IDLE) begin
      if (pop) begin
        cur  <= signed'(mem[rd_ptr]);
        prev <= '0;
        div  <= '0;
        step <= '0;
      end
    end else begin
      div <= tick ? '0 : div + divwidth'(1);
      if (tick) begin
        acc  <= acc + accwidth'(delta);
        step <= step + steplog2'(1);
        if (pop) begin
          prev <= cur;
          cur  <= signed'(mem[rd_ptr]);
        end else if (hold) begin
          // Zero slope while starved: the output parks on the last sample.
          prev <= cur;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_interp_fifo.sv
// Randomised and directed bench for audio_interp_fifo, checked every cycle against a
// segment/queue model of the interpolator plus literal waypoints.
module tb_audio_interp_fifo;

  localparam int W       = 16;
  localparam int N       = 4;
  localparam int STEPDIV = 4;
  localparam int SEG     = N * STEPDIV;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   ucount = 0;

  audio_interp_fifo_if #(.signalwidth(W)) bus ();

  audio_interp_fifo #(
    .signalwidth(W),
    .steplog2(2),
    .stepdiv(STEPDIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a segment runs from m_from to m_to over SEG clocks; after k completed
  // steps the output is floor(m_from + k*(m_to-m_from)/N).
  int  q[$];
  bit  m_live = 0;
  bit  m_idle = 1;
  int  m_from = 0;
  int  m_to   = 0;
  int  m_e    = 0;
  bit  m_push;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_live = 1;
      m_idle = 1;
      m_from = 0;
      m_to   = 0;
      m_e    = 0;
    end else begin
      m_push = bus.in_valid && (q.size() < 4);
      if (m_idle) begin
        if (q.size() > 0) begin
          m_from = 0;
          m_to   = q.pop_front();
          m_idle = 0;
          m_e    = 0;
        end
      end else begin
        m_e++;
        if (m_e == SEG) begin
          m_from = m_to;
          m_e    = 0;
          if (q.size() > 0) m_to = q.pop_front();
        end
      end
      if (m_push) q.push_back(int'($signed(bus.in_data)));
    end
  end

  function automatic logic [15:0] exp_d();
    longint scaled;
    logic [15:0] v;
    scaled = longint'(m_from) * N + longint'(m_e / STEPDIV) * longint'(m_to - m_from);
    v = 16'(scaled >>> 2);
    return v ^ 16'h8000;
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      check("model_d", bus.d, exp_d());
      check("model_in_ready", bus.in_ready, q.size() < 4);
      check("model_fifo_level", bus.fifo_level, q.size());
      check("model_underrun", bus.underrun, !m_idle && (m_e == SEG - 1) && (q.size() == 0));
      if (bus.underrun) ucount++;
    end
  end

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  // Offers one sample and returns the cycle number of the accepting edge.
  task automatic push(input logic [15:0] data, output int edge_cyc);
    bit rdy;
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1;
    end
    bus.in_valid = 1'b0;
    edge_cyc = cyc;
    check("push_accepted", done, 1);
  endtask

  int p, p2, c[6];

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    do_reset(2);
    check("rst_d", bus.d, 16'h8000);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_level", bus.fifo_level, 0);
    check("rst_underrun", bus.underrun, 0);

    // Single positive sample
    push(16'h0400, p);
    step_to(p + 5);  check("single_s1", bus.d, 16'h8100);
    step_to(p + 9);  check("single_s2", bus.d, 16'h8200);
    step_to(p + 13); check("single_s3", bus.d, 16'h8300);
    step_to(p + 17); check("single_s4", bus.d, 16'h8400);
    ucount = 0;
    step_to(p + 33);
    check("single_hold_d", bus.d, 16'h8400);
    check("single_underrun_once", ucount, 1);

    // Rising then falling segment
    do_reset(1);
    push(16'h0400, p);
    push(16'hFC00, p2);
    check("neg_b2b_push", p2, p + 1);
    ucount = 0;
    step_to(p + 21); check("neg_s1", bus.d, 16'h8200);
    check("neg_no_underrun", ucount, 0);
    step_to(p + 25); check("neg_s2", bus.d, 16'h8000);
    step_to(p + 29); check("neg_s3", bus.d, 16'h7E00);
    step_to(p + 33); check("neg_s4", bus.d, 16'h7C00);

    // Full FIFO back-pressure
    do_reset(1);
    for (int i = 0; i < 5; i++) push(16'($urandom), c[i]);
    check("full_b2b", c[4], c[0] + 4);
    check("full_level", bus.fifo_level, 4);
    check("full_in_ready", bus.in_ready, 0);
    push(16'($urandom), c[5]);
    check("full_sixth_accept", c[5], c[0] + 18);

    // Full-scale extremes
    do_reset(1);
    push(16'h7FFF, p);
    push(16'h8000, p2);
    step_to(p + 17); check("ext_top", bus.d, 16'hFFFF);
    step_to(p + 33); check("ext_bottom", bus.d, 16'h0000);

    // Reset in the middle of a ramp with samples queued
    do_reset(1);
    push(16'h1000, p);
    push(16'h2000, p2);
    push(16'h3000, p2);
    push(16'h4000, p2);
    step_to(p + 7);
    check("mid_level", bus.fifo_level, 3);
    check("mid_d", bus.d, 16'h8400);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h7000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_rst_d", bus.d, 16'h8000);
    check("mid_rst_level", bus.fifo_level, 0);
    push(16'h0400, p);
    step_to(p + 4); check("restart_flat", bus.d, 16'h8000);
    step_to(p + 5); check("restart_s1", bus.d, 16'h8100);

    // Random traffic: sparse (underruns) then dense (back-pressure), rare resets
    do_reset(1);
    for (int i = 0; i < 1600; i++) begin
      reset        = ($urandom_range(0, 399) == 0);
      bus.in_valid = ($urandom_range(0, 99) < ((i < 800) ? 5 : 25));
      bus.in_data  = 16'($urandom);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
